// File: rtl/video_timing_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | video_timing_gen_if                                                      |
// | Raster timing bundle: run enable in, syncs/DE/coordinates/markers out.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface video_timing_gen_if #(
    parameter int HW = 12,
    parameter int VW = 11
);
    logic          en_i;
    logic          hs_o;
    logic          vs_o;
    logic          de_o;
    logic [HW-1:0] x_o;
    logic [VW-1:0] y_o;
    logic          sof_o;
    logic          eol_o;

    modport master (
        input  en_i,
        output hs_o, vs_o, de_o, x_o, y_o, sof_o, eol_o
    );

    modport slave (
        output en_i,
        input  hs_o, vs_o, de_o, x_o, y_o, sof_o, eol_o
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | video_timing_gen                                                         |
// | Free-running raster counters with registered hs/vs/de/x/y/sof/eol.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module video_timing_gen #(
    parameter int H_WIDTH  = 1920,
    parameter int H_START  = 2008,
    parameter int H_SYNC   = 44,
    parameter int H_TOTAL  = 2200,
    parameter int V_HEIGHT = 1080,
    parameter int V_START  = 1084,
    parameter int V_SYNC   = 5,
    parameter int V_TOTAL  = 1125,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  wire logic          clk_i,
    input  wire logic          rst_n_i,
    video_timing_gen_if.master vid
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    // Sync end bounds carry one extra bit so H_START+H_SYNC == 2**HW cannot alias to 0.
    localparam logic [HW-1:0] c_h_width = HW'(H_WIDTH);
    localparam logic [HW-1:0] c_h_start = HW'(H_START);
    localparam logic [HW:0]   c_h_send  = (HW+1)'(H_START + H_SYNC);
    localparam logic [HW-1:0] c_h_last  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] c_v_height = VW'(V_HEIGHT);
    localparam logic [VW-1:0] c_v_start = VW'(V_START);
    localparam logic [VW:0]   c_v_send  = (VW+1)'(V_START + V_SYNC);
    localparam logic [VW-1:0] c_v_last  = VW'(V_TOTAL - 1);

    if (!(H_WIDTH < H_START)) begin : g_chk_h_start
        $error("video_timing_gen: H_WIDTH must be less than H_START");
    end
    if (!(H_START + H_SYNC <= H_TOTAL)) begin : g_chk_h_total
        $error("video_timing_gen: H_START+H_SYNC exceeds H_TOTAL");
    end
    if (!(V_HEIGHT < V_START)) begin : g_chk_v_start
        $error("video_timing_gen: V_HEIGHT must be less than V_START");
    end
    if (!(V_START + V_SYNC <= V_TOTAL)) begin : g_chk_v_total
        $error("video_timing_gen: V_START+V_SYNC exceeds V_TOTAL");
    end
    if (!(H_SYNC >= 1 && V_SYNC >= 1)) begin : g_chk_sync_w
        $error("video_timing_gen: sync widths must be at least 1");
    end

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;

    always_comb begin
        h_d   = '0;
        v_d   = '0;
        hs_d  = ~HS_POL;
        vs_d  = ~VS_POL;
        de_d  = 1'b0;
        x_d   = '0;
        y_d   = '0;
        sof_d = 1'b0;
        eol_d = 1'b0;
        if (vid.en_i) begin
            // Outputs decode the pre-increment position, giving one cycle of latency.
            hs_d  = (h_q >= c_h_start && {1'b0, h_q} < c_h_send) ? HS_POL : ~HS_POL;
            vs_d  = (v_q >= c_v_start && {1'b0, v_q} < c_v_send) ? VS_POL : ~VS_POL;
            de_d  = (h_q < c_h_width) && (v_q < c_v_height);
            x_d   = h_q;
            y_d   = v_q;
            sof_d = (h_q == '0) && (v_q == '0);
            eol_d = (h_q == c_h_last);
            if (h_q == c_h_last) begin
                h_d = '0;
                v_d = (v_q == c_v_last) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
                v_d = v_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            sof_q <= 1'b0;
            eol_q <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            x_q   <= x_d;
            y_q   <= y_d;
            sof_q <= sof_d;
            eol_q <= eol_d;
        end
    end

    assign vid.hs_o  = hs_q;
    assign vid.vs_o  = vs_q;
    assign vid.de_o  = de_q;
    assign vid.x_o   = x_q;
    assign vid.y_o   = y_q;
    assign vid.sof_o = sof_q;
    assign vid.eol_o = eol_q;
endmodule
`default_nettype wire
